// File: rtl/dly_train_ctrl.sv
// Delay-line training controller: sweeps the tap upward to find the first passing
// window of at least MIN_EYE taps, then steps back down to the window centre.
module dly_train_ctrl #(
    parameter int INIT_TAP   = 0,
    parameter int SETTLE_CYC = 4,
    parameter int MIN_EYE    = 4
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       START,
    input  logic       PASS,
    input  logic       PASS_VLD,
    input  logic       CFLAG,
    output logic       LOADN,
    output logic       MOVE,
    output logic       DIRECTION,
    output logic [6:0] TAP,
    output logic       DONE,
    output logic       FAIL
);
    typedef enum logic [3:0] {
        IDLE, LOAD, SETTLE, SAMPLE, STEP, GAP, CTR_STEP, CTR_GAP, FINISH
    } state_t;

    localparam logic [6:0] INIT_TAP7   = 7'(INIT_TAP);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] MIN_EYE8    = 8'(MIN_EYE);

    state_t     state, state_n;
    logic [7:0] settle_cnt, settle_cnt_n;
    logic [6:0] tap, tap_n;
    logic [6:0] left, left_n;
    logic [6:0] right, right_n;
    logic       in_eye, in_eye_n;
    logic       centering, centering_n;
    logic       dir, dir_n;
    logic [7:0] step_cnt, step_cnt_n;
    logic       done, done_n;
    logic       fail, fail_n;

    logic       eye_ok;
    logic [7:0] span8, center8, dn8;

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            tap        <= INIT_TAP7;
            left       <= 7'd0;
            right      <= 7'd0;
            in_eye     <= 1'b0;
            centering  <= 1'b0;
            dir        <= 1'b0;
            step_cnt   <= 8'd0;
            done       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            tap        <= tap_n;
            left       <= left_n;
            right      <= right_n;
            in_eye     <= in_eye_n;
            centering  <= centering_n;
            dir        <= dir_n;
            step_cnt   <= step_cnt_n;
            done       <= done_n;
            fail       <= fail_n;
        end
    end

    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        tap_n        = tap;
        left_n       = left;
        right_n      = right;
        in_eye_n     = in_eye;
        centering_n  = centering;
        dir_n        = dir;
        step_cnt_n   = step_cnt;
        done_n       = done;
        fail_n       = fail;
        eye_ok       = 1'b0;
        span8        = 8'd0;
        center8      = 8'd0;
        dn8          = 8'd0;

        case (state)
            IDLE: begin
                if (START) state_n = LOAD;
            end
            LOAD: begin
                tap_n       = INIT_TAP7;
                left_n      = 7'd0;
                right_n     = 7'd0;
                in_eye_n    = 1'b0;
                centering_n = 1'b0;
                dir_n       = 1'b0;
                state_n     = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = 8'd0;
                    state_n      = centering ? CTR_STEP : SAMPLE;
                end else begin
                    settle_cnt_n = settle_cnt + 8'd1;
                end
            end
            SAMPLE: begin
                if (PASS_VLD) begin
                    if (PASS && !in_eye) begin
                        left_n   = tap;
                        in_eye_n = 1'b1;
                    end else if (!PASS && in_eye) begin
                        // Run closed by a failing tap; its width is tap - left.
                        in_eye_n = 1'b0;
                        right_n  = tap - 7'd1;
                        if (({1'b0, tap} - {1'b0, left}) >= MIN_EYE8) eye_ok = 1'b1;
                    end

                    if (!eye_ok && (tap == 7'd127 || CFLAG)) begin
                        if (in_eye_n && (({1'b0, tap} - {1'b0, left_n} + 8'd1) >= MIN_EYE8)) begin
                            eye_ok  = 1'b1;
                            right_n = tap;
                        end else begin
                            fail_n  = 1'b1;
                            state_n = FINISH;
                        end
                    end

                    if (eye_ok) begin
                        span8   = {1'b0, right_n} - {1'b0, left_n};
                        center8 = {1'b0, left_n} + (span8 >> 1);
                        dn8     = {1'b0, tap} - center8;
                        if (dn8 == 8'd0) begin
                            done_n  = 1'b1;
                            state_n = FINISH;
                        end else begin
                            // Direction flips here so it is stable a cycle before the first down MOVE.
                            step_cnt_n  = dn8;
                            centering_n = 1'b1;
                            dir_n       = 1'b1;
                            state_n     = SETTLE;
                        end
                    end else if (state_n == SAMPLE) begin
                        state_n = STEP;
                    end
                end
            end
            STEP: begin
                state_n = GAP;
            end
            GAP: begin
                tap_n   = tap + 7'd1;
                state_n = SETTLE;
            end
            CTR_STEP: begin
                state_n = CTR_GAP;
            end
            CTR_GAP: begin
                tap_n      = tap - 7'd1;
                step_cnt_n = step_cnt - 8'd1;
                if (step_cnt == 8'd1) begin
                    done_n      = 1'b1;
                    centering_n = 1'b0;
                    state_n     = FINISH;
                end else begin
                    state_n = SETTLE;
                end
            end
            FINISH: begin
                if (START) begin
                    done_n  = 1'b0;
                    fail_n  = 1'b0;
                    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign LOADN     = (state != LOAD);
    assign MOVE      = (state == STEP) || (state == CTR_STEP);
    assign DIRECTION = dir;
    assign TAP       = tap;
    assign DONE      = done;
    assign FAIL      = fail;

endmodule

// File: tb/tb_dly_train_ctrl.sv
// Bench for dly_train_ctrl: emulates the delay line and data checker around the
// controller and compares each training run against a window-search model.
module tb_dly_train_ctrl;
    localparam int INIT_TAP   = 0;
    localparam int SETTLE_CYC = 4;
    localparam int MIN_EYE    = 4;

    logic       SCLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       PASS = 1'b0;
    logic       PASS_VLD = 1'b0;
    logic       CFLAG = 1'b0;
    logic       LOADN, MOVE, DIRECTION, DONE, FAIL;
    logic [6:0] TAP;

    int   vectors = 0;
    int   errors  = 0;
    bit   pass_tbl [128];
    int   phys = INIT_TAP;
    logic prev_move = 1'b0, prev_dir = 1'b0, prev_loadn = 1'b1;
    int   up_cnt = 0, dn_cnt = 0, vld_ctr = 0;

    dly_train_ctrl #(
        .INIT_TAP(INIT_TAP), .SETTLE_CYC(SETTLE_CYC), .MIN_EYE(MIN_EYE)
    ) dut (
        .SCLK(SCLK), .RST(RST), .START(START), .PASS(PASS), .PASS_VLD(PASS_VLD),
        .CFLAG(CFLAG), .LOADN(LOADN), .MOVE(MOVE), .DIRECTION(DIRECTION),
        .TAP(TAP), .DONE(DONE), .FAIL(FAIL)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_runs(input int lo1, input int hi1, input int lo2, input int hi2);
        for (int t = 0; t < 128; t++)
            pass_tbl[t] = ((t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2));
    endtask

    // Window search over the pass table: first passing run of MIN_EYE or more taps.
    task automatic model(output int up, output int dn, output int tap,
                         output bit done, output bit fail);
        int rs = -1;
        int l = 0, r = 0, e = 0;
        bit found = 1'b0;
        for (int t = INIT_TAP; t < 128; t++) begin
            if (!found) begin
                if (pass_tbl[t]) begin
                    if (rs < 0) rs = t;
                    if (t == 127 && (128 - rs) >= MIN_EYE) begin
                        found = 1'b1; l = rs; r = 127; e = 127;
                    end
                end else if (rs >= 0) begin
                    if ((t - rs) >= MIN_EYE) begin
                        found = 1'b1; l = rs; r = t - 1; e = t;
                    end
                    rs = -1;
                end
            end
        end
        if (found) begin
            up = e - INIT_TAP; tap = l + (r - l) / 2; dn = e - tap; done = 1'b1; fail = 1'b0;
        end else begin
            up = 127 - INIT_TAP; dn = 0; tap = 127; done = 1'b0; fail = 1'b1;
        end
    endtask

    // Delay-line emulation, data-checker strobes and per-cycle output rules.
    initial forever begin
        @(negedge SCLK);
        #2;
        if (RST) begin
            phys = INIT_TAP; prev_move = 1'b0; prev_dir = 1'b0; prev_loadn = 1'b1;
        end else begin
            if (prev_move) phys = prev_dir ? phys - 1 : phys + 1;
            if (!prev_loadn) begin
                phys = INIT_TAP; up_cnt = 0; dn_cnt = 0;
            end
            if (MOVE && !prev_move) begin
                if (DIRECTION) dn_cnt++;
                else up_cnt++;
            end
            check("move_spacing", int'(MOVE && prev_move), 0);
            check("move_with_load", int'(MOVE && !LOADN), 0);
            if (MOVE || prev_move) check("dir_stable", int'(DIRECTION), int'(prev_dir));
            if (!prev_move) check("tap_track", int'(TAP), phys);
            check("done_and_fail", int'(DONE && FAIL), 0);
            prev_move = MOVE; prev_dir = DIRECTION; prev_loadn = LOADN;
        end
        vld_ctr  = (vld_ctr == 2) ? 0 : vld_ctr + 1;
        PASS_VLD = (vld_ctr == 0);
        PASS     = (phys >= 0 && phys < 128) ? pass_tbl[phys] : 1'b0;
        CFLAG    = (phys == 127) && !DIRECTION;
    end

    task automatic start_run();
        @(negedge SCLK); #1;
        START = 1'b1;
        @(negedge SCLK); #1;
        START = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int lit_up, input int lit_dn,
                                input int lit_tap, input int lit_done);
        int m_up, m_dn, m_tap, n;
        bit m_done, m_fail;
        model(m_up, m_dn, m_tap, m_done, m_fail);
        check({tag, "_model_up"}, m_up, lit_up);
        check({tag, "_model_dn"}, m_dn, lit_dn);
        check({tag, "_model_tap"}, m_tap, lit_tap);
        check({tag, "_model_done"}, int'(m_done), lit_done);
        n = 0;
        while (!(DONE || FAIL) && n < 4000) begin
            @(negedge SCLK); #1;
            n++;
        end
        check({tag, "_timeout"}, int'(n < 4000), 1);
        repeat (5) @(negedge SCLK);
        #1;
        check({tag, "_up_pulses"}, up_cnt, m_up);
        check({tag, "_dn_pulses"}, dn_cnt, m_dn);
        check({tag, "_tap"}, int'(TAP), m_tap);
        check({tag, "_done"}, int'(DONE), int'(m_done));
        check({tag, "_fail_flag"}, int'(FAIL), int'(m_fail));
    endtask

    initial begin
        int n, moves, lows;
        set_runs(1, 0, 1, 0);
        repeat (3) @(negedge SCLK);
        #1 RST = 1'b0;
        repeat (4) @(negedge SCLK);
        #1 RST = 1'b1;
        #1;
        check("rst_loadn", int'(LOADN), 1);
        check("rst_move", int'(MOVE), 0);
        check("rst_dir", int'(DIRECTION), 0);
        check("rst_tap", int'(TAP), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_fail_flag", int'(FAIL), 0);
        @(negedge SCLK); #1 RST = 1'b0;
        repeat (2) @(negedge SCLK);

        set_runs(20, 40, 1, 0);
        start_run();
        finish_check("eye_20_40", 41, 11, 30, 1);

        set_runs(10, 12, 50, 60);
        start_run();
        finish_check("two_runs", 61, 6, 55, 1);

        set_runs(1, 0, 1, 0);
        start_run();
        finish_check("no_eye", 127, 0, 127, 0);

        set_runs(100, 127, 1, 0);
        start_run();
        finish_check("top_eye", 127, 14, 113, 1);

        // Abort a sweep while the step at tap 35 is on the wire.
        set_runs(20, 40, 1, 0);
        start_run();
        n = 0;
        while (!(TAP == 7'd35 && MOVE) && n < 2000) begin
            @(negedge SCLK); #1;
            n++;
        end
        check("abort_reach_35", int'(n < 2000), 1);
        RST = 1'b1;
        #1;
        check("abort_move", int'(MOVE), 0);
        check("abort_tap", int'(TAP), 0);
        check("abort_loadn", int'(LOADN), 1);
        check("abort_done", int'(DONE), 0);
        @(negedge SCLK); #1 RST = 1'b0;
        moves = 0;
        repeat (10) begin
            @(negedge SCLK); #1;
            if (MOVE) moves++;
        end
        check("abort_no_move", moves, 0);
        START = 1'b1;
        lows = 0;
        repeat (6) begin
            @(negedge SCLK); #1;
            START = 1'b0;
            if (!LOADN) lows++;
        end
        check("restart_loadn_cycles", lows, 1);
        check("restart_tap", int'(TAP), 0);
        finish_check("restart", 41, 11, 30, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
